// File: rtl/mines_pkg.sv
// Shared types and helpers for the minesweeper game controller.
//   state_t   : controller FSM states
//   DIR_*     : encodings of the 2-bit move direction
//   w_of()    : index/counter width helper that never returns zero
package mines_pkg;

  typedef enum logic [2:0] {
    StClear,
    StPlay,
    StFlagRd,
    StFlagWr,
    StSelRd,
    StSelWr,
    StLose,
    StWin
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Bits needed to hold values 0..n-1, at least 1.
  function automatic int unsigned w_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mines_cursor.sv
// Board cursor for the minesweeper controller.
// Edge behaviour is set by macro MINES_CURSOR_WRAP_EN: defined -> wrap to the
// opposite edge, undefined -> saturate (move past an edge is ignored).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous return to (0,0)
//   step      : move one cell in dir this cycle
//   dir       : 0=up 1=down 2=left 3=right
//   cur_row/cur_col : cursor position
module mines_cursor
  import mines_pkg::*;
#(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    step,
  input  logic [1:0]              dir,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic [$clog2(COLS)-1:0] cur_col
);

  localparam int unsigned RW = w_of(ROWS);
  localparam int unsigned CW = w_of(COLS);
  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
  localparam logic [CW-1:0] ColLast = CW'(COLS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (step) begin
      unique case (dir)
        DIR_UP: begin
          if (row_q != '0) row_d = row_q - RW'(1);
`ifdef MINES_CURSOR_WRAP_EN
          else row_d = RowLast;
`endif
        end
        DIR_DOWN: begin
          if (row_q != RowLast) row_d = row_q + RW'(1);
`ifdef MINES_CURSOR_WRAP_EN
          else row_d = '0;
`endif
        end
        DIR_LEFT: begin
          if (col_q != '0) col_d = col_q - CW'(1);
`ifdef MINES_CURSOR_WRAP_EN
          else col_d = ColLast;
`endif
        end
        DIR_RIGHT: begin
          if (col_q != ColLast) col_d = col_q + CW'(1);
`ifdef MINES_CURSOR_WRAP_EN
          else col_d = '0;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign cur_row = row_q;
  assign cur_col = col_q;

endmodule

// File: rtl/mines_game_ctrl.sv
// Minesweeper game controller: board-clear sweep, cursor, flag/reveal
// read-modify-write against a cell RAM with 1-cycle registered read, flag
// budget and win/lose detection. Cursor edge wrap via MINES_CURSOR_WRAP_EN.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start/move_req/sel_req/flag_req, dir : button pulses and move direction
//   cell_mine/open/flag         : RAM read data (valid 1 cycle after addr)
//   addr_row/col, wr_en, wr_open, wr_flag : RAM address and write port
//   cur_row/col                 : cursor for display
//   flags_left, opened_cnt      : flag budget, safe cells revealed
//   busy, game_over, win        : status
module mines_game_ctrl
  import mines_pkg::*;
#(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned MINES = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            move_req,
  input  logic [1:0]                      dir,
  input  logic                            sel_req,
  input  logic                            flag_req,
  input  logic                            cell_mine,
  input  logic                            cell_open,
  input  logic                            cell_flag,
  output logic [$clog2(ROWS)-1:0]         addr_row,
  output logic [$clog2(COLS)-1:0]         addr_col,
  output logic                            wr_en,
  output logic                            wr_open,
  output logic                            wr_flag,
  output logic [$clog2(ROWS)-1:0]         cur_row,
  output logic [$clog2(COLS)-1:0]         cur_col,
  output logic [$clog2(MINES+1)-1:0]      flags_left,
  output logic [$clog2(ROWS*COLS+1)-1:0]  opened_cnt,
  output logic                            busy,
  output logic                            game_over,
  output logic                            win
);

  localparam int unsigned RW = w_of(ROWS);
  localparam int unsigned CW = w_of(COLS);
  localparam int unsigned FW = w_of(MINES + 1);
  localparam int unsigned OW = w_of(ROWS * COLS + 1);
  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
  localparam logic [CW-1:0] ColLast = CW'(COLS - 1);
  localparam logic [FW-1:0] MinesV  = FW'(MINES);
  localparam logic [OW-1:0] SafeV   = OW'(ROWS * COLS - MINES);

  state_t        state_q, state_d;
  logic [RW-1:0] sweep_row_q, sweep_row_d;
  logic [CW-1:0] sweep_col_q, sweep_col_d;
  logic [FW-1:0] flags_q, flags_d;
  logic [OW-1:0] opened_q, opened_d;
  logic          over_q, over_d;
  logic          win_q, win_d;
  logic          cur_step;
  logic          wr_en_raw;

  mines_cursor #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_cursor (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .step    (cur_step),
    .dir     (dir),
    .cur_row (cur_row),
    .cur_col (cur_col)
  );

  always_comb begin
    state_d     = state_q;
    sweep_row_d = sweep_row_q;
    sweep_col_d = sweep_col_q;
    flags_d     = flags_q;
    opened_d    = opened_q;
    over_d      = over_q;
    win_d       = win_q;
    cur_step    = 1'b0;
    wr_en_raw   = 1'b0;
    wr_open     = 1'b0;
    wr_flag     = 1'b0;

    unique case (state_q)
      StClear: begin
        wr_en_raw = 1'b1;
        if (sweep_col_q == ColLast) begin
          sweep_col_d = '0;
          if (sweep_row_q == RowLast) begin
            sweep_row_d = '0;
            state_d     = StPlay;
          end else begin
            sweep_row_d = sweep_row_q + RW'(1);
          end
        end else begin
          sweep_col_d = sweep_col_q + CW'(1);
        end
      end
      StPlay: begin
        if (sel_req)       state_d  = StSelRd;
        else if (flag_req) state_d  = StFlagRd;
        else if (move_req) cur_step = 1'b1;
      end
      StFlagRd: state_d = StFlagWr;
      StFlagWr: begin
        state_d = StPlay;
        if (!cell_open) begin
          if (cell_flag) begin
            wr_en_raw = 1'b1;
            wr_open   = cell_open;
            wr_flag   = 1'b0;
            if (flags_q != MinesV) flags_d = flags_q + FW'(1);
          end else if (flags_q != '0) begin
            wr_en_raw = 1'b1;
            wr_open   = cell_open;
            wr_flag   = 1'b1;
            flags_d   = flags_q - FW'(1);
          end
        end
      end
      StSelRd: state_d = StSelWr;
      StSelWr: begin
        state_d = StPlay;
        if (!cell_open && !cell_flag) begin
          wr_en_raw = 1'b1;
          wr_open   = 1'b1;
          if (cell_mine) begin
            over_d  = 1'b1;
            state_d = StLose;
          end else begin
            opened_d = opened_q + OW'(1);
            if (opened_q + OW'(1) == SafeV) begin
              win_d   = 1'b1;
              state_d = StWin;
            end
          end
        end
      end
      StLose, StWin: ;
      default: state_d = StClear;
    endcase

    // New game overrides everything; a pending RMW write is abandoned.
    if (start) begin
      state_d     = StClear;
      sweep_row_d = '0;
      sweep_col_d = '0;
      flags_d     = MinesV;
      opened_d    = '0;
      over_d      = 1'b0;
      win_d       = 1'b0;
      cur_step    = 1'b0;
      if (state_q != StClear) wr_en_raw = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StClear;
      sweep_row_q <= '0;
      sweep_col_q <= '0;
      flags_q     <= MinesV;
      opened_q    <= '0;
      over_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_row_q <= sweep_row_d;
      sweep_col_q <= sweep_col_d;
      flags_q     <= flags_d;
      opened_q    <= opened_d;
      over_q      <= over_d;
      win_q       <= win_d;
    end
  end

  // No RAM writes while reset is held.
  assign wr_en      = wr_en_raw & ~rst;
  assign addr_row   = (state_q == StClear) ? sweep_row_q : cur_row;
  assign addr_col   = (state_q == StClear) ? sweep_col_q : cur_col;
  assign flags_left = flags_q;
  assign opened_cnt = opened_q;
  assign busy       = (state_q != StPlay);
  assign game_over  = over_q;
  assign win        = win_q;

endmodule

// File: tb/tb_mines_game_ctrl.sv
// Directed bench for mines_game_ctrl on a 4x4 board with one mine at (1,1).
// A small cell-RAM model answers reads; every expected RAM write is queued
// when the stimulus is issued and checked when wr_en appears.
module tb_mines_game_ctrl;
  import mines_pkg::*;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned MINES = 1;
  localparam int          MINE_CELL = 5;

  logic       clk = 1'b0;
  logic       rst, start, move_req, sel_req, flag_req;
  logic [1:0] dir;
  logic       cell_mine, cell_open, cell_flag;
  logic [1:0] addr_row, addr_col, cur_row, cur_col;
  logic       wr_en, wr_open, wr_flag;
  logic [0:0] flags_left;
  logic [4:0] opened_cnt;
  logic       busy, game_over, win;

  mines_game_ctrl #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .MINES (MINES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .move_req   (move_req),
    .dir        (dir),
    .sel_req    (sel_req),
    .flag_req   (flag_req),
    .cell_mine  (cell_mine),
    .cell_open  (cell_open),
    .cell_flag  (cell_flag),
    .addr_row   (addr_row),
    .addr_col   (addr_col),
    .wr_en      (wr_en),
    .wr_open    (wr_open),
    .wr_flag    (wr_flag),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .flags_left (flags_left),
    .opened_cnt (opened_cnt),
    .busy       (busy),
    .game_over  (game_over),
    .win        (win)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int   addr;
    logic op;
    logic fl;
  } wr_t;
  wr_t wr_q[$];

  // Cell RAM model: registered read, write on wr_en.
  logic mem_open [16];
  logic mem_flag [16];
  always @(posedge clk) begin
    cell_mine <= (int'({addr_row, addr_col}) == MINE_CELL);
    cell_open <= mem_open[{addr_row, addr_col}];
    cell_flag <= mem_flag[{addr_row, addr_col}];
    if (wr_en === 1'b1) begin
      mem_open[{addr_row, addr_col}] <= wr_open;
      mem_flag[{addr_row, addr_col}] <= wr_flag;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (wr_en !== 1'b0) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {30'd0, wr_en, 1'b0}, 32'd0);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 32'({addr_row, addr_col}), 32'(e.addr));
        chk("wr_open", 32'(wr_open), 32'(e.op));
        chk("wr_flag", 32'(wr_flag), 32'(e.fl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int cr = 0;
  int cc = 0;

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_wr(input int a, input logic op, input logic fl);
    wr_t e;
    e.addr = a;
    e.op   = op;
    e.fl   = fl;
    wr_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 16; i++) push_wr(i, 1'b0, 1'b0);
  endtask

  task automatic do_move(input logic [1:0] d);
    dir      = d;
    move_req = 1'b1;
    cycle(1);
    move_req = 1'b0;
  endtask

  task automatic do_flag();
    flag_req = 1'b1;
    cycle(1);
    flag_req = 1'b0;
    cycle(2);
  endtask

  task automatic do_sel();
    sel_req = 1'b1;
    cycle(1);
    sel_req = 1'b0;
    cycle(2);
  endtask

  // Moves never cross an edge, so the path is valid with or without wrap.
  task automatic move_to(input int r, input int c);
    while (cr < r) begin do_move(DIR_DOWN);  cr++; end
    while (cr > r) begin do_move(DIR_UP);    cr--; end
    while (cc < c) begin do_move(DIR_RIGHT); cc++; end
    while (cc > c) begin do_move(DIR_LEFT);  cc--; end
  endtask

  task automatic new_game();
    push_clear();
    start = 1'b1;
    cycle(1);
    start = 1'b0;
    cycle(16);
    cr = 0;
    cc = 0;
  endtask

  int er, ec, k;

  initial begin
    rst = 1'b1; start = 1'b0; move_req = 1'b0; sel_req = 1'b0; flag_req = 1'b0;
    dir = 2'd0;
    for (int i = 0; i < 16; i++) begin
      mem_open[i] = 1'b1;
      mem_flag[i] = 1'b1;
    end
    cycle(2);

    // Reset state
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_flags", 32'(flags_left), 32'(MINES));
    chk("rst_opened", 32'(opened_cnt), 32'd0);
    chk("rst_cursor", 32'({cur_row, cur_col}), 32'd0);
    chk("rst_over_win", 32'({game_over, win}), 32'd0);

    // Clear sweep: 16 writes, row-major, then PLAY
    push_clear();
    rst = 1'b0;
    cycle(16);
    chk("clear_done_busy", 32'(busy), 32'd0);
    chk("clear_q_drained", 32'(wr_q.size()), 32'd0);
    chk("clear_flags", 32'(flags_left), 32'(MINES));
    chk("clear_cursor", 32'({cur_row, cur_col}), 32'd0);

    // Edge moves from (0,0)
    do_move(DIR_UP);
`ifdef MINES_CURSOR_WRAP_EN
    er = 3; ec = 0;
`else
    er = 0; ec = 0;
`endif
    chk("move_up_row", 32'(cur_row), 32'(er));
    chk("move_up_col", 32'(cur_col), 32'(ec));
    do_move(DIR_LEFT);
`ifdef MINES_CURSOR_WRAP_EN
    er = 3; ec = 3;
`else
    er = 0; ec = 0;
`endif
    chk("move_left_row", 32'(cur_row), 32'(er));
    chk("move_left_col", 32'(cur_col), 32'(ec));
    new_game();
    chk("ng_cursor", 32'({cur_row, cur_col}), 32'd0);

    // Flag budget: set, exhausted, clear
    push_wr(0, 1'b0, 1'b1);
    do_flag();
    chk("flag_set_left", 32'(flags_left), 32'(MINES - 1));
    move_to(0, 1);
    do_flag();
    chk("flag_empty_left", 32'(flags_left), 32'd0);
    move_to(0, 0);
    push_wr(0, 1'b0, 1'b0);
    do_flag();
    chk("flag_clr_left", 32'(flags_left), 32'(MINES));

    // sel beats move in the same cycle
    push_wr(0, 1'b1, 1'b0);
    dir = DIR_DOWN; sel_req = 1'b1; move_req = 1'b1;
    cycle(1);
    sel_req = 1'b0; move_req = 1'b0;
    cycle(2);
    chk("prio_cursor", 32'({cur_row, cur_col}), 32'd0);
    chk("prio_opened", 32'(opened_cnt), 32'd1);
    do_sel();
    chk("rereveal_opened", 32'(opened_cnt), 32'd1);

    // start while in FLAG_RD abandons the flag
    move_to(0, 1);
    flag_req = 1'b1;
    cycle(1);
    flag_req = 1'b0;
    chk("flag_rd_busy", 32'(busy), 32'd1);
    new_game();
    chk("abort_flags", 32'(flags_left), 32'(MINES));
    chk("abort_opened", 32'(opened_cnt), 32'd0);
    chk("abort_q_drained", 32'(wr_q.size()), 32'd0);

    // Reveal every safe cell
    k = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        move_to(r, c);
        if (r * 4 + c != MINE_CELL) begin
          push_wr(r * 4 + c, 1'b1, 1'b0);
          do_sel();
          k++;
          chk("win_opened", 32'(opened_cnt), 32'(k));
          chk("win_flag", 32'(win), (k == 15) ? 32'd1 : 32'd0);
        end
      end
    end
    chk("win_busy", 32'(busy), 32'd1);
    chk("win_no_over", 32'(game_over), 32'd0);
    do_sel();
    chk("win_hold_opened", 32'(opened_cnt), 32'd15);

    // Reveal the mine
    new_game();
    chk("ng_win_cleared", 32'(win), 32'd0);
    move_to(1, 1);
    push_wr(MINE_CELL, 1'b1, 1'b0);
    do_sel();
    chk("lose_over", 32'(game_over), 32'd1);
    chk("lose_busy", 32'(busy), 32'd1);
    chk("lose_opened", 32'(opened_cnt), 32'd0);
    do_move(DIR_DOWN);
    do_flag();
    do_sel();
    chk("lose_cursor", 32'({cur_row, cur_col}), 32'd5);
    chk("lose_flags", 32'(flags_left), 32'(MINES));
    chk("lose_sticky", 32'(game_over), 32'd1);
    new_game();
    chk("ng_over_cleared", 32'(game_over), 32'd0);
    chk("ng_busy", 32'(busy), 32'd0);
    chk("final_q_drained", 32'(wr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mines_game_ctrl.md
Name: mines_game_ctrl

Overview:
- Parametrised game controller for the minesweeper board: owns the cursor, board-clear sweep, reveal/flag read-modify-write, flag budget, and win/lose detection.
- Sits between the debounced button pulses and the board cell RAM, which holds per-cell mine/open/flag bits and has 1-cycle registered read.
- Generalises the fixed 3-bit game FSM to an ROWS x COLS board with counters and explicit RAM sequencing.

Parameters:
- ROWS, 8, board rows (>=2)
- COLS, 8, board columns (>=2)
- MINES, 10, mines placed on the board; initial flag budget (1..ROWS*COLS-1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin new game (clear sweep)
- move_req  in  1  pulse: move cursor one cell in dir
- dir  in  2  0=up 1=down 2=left 3=right
- sel_req  in  1  pulse: reveal cursor cell
- flag_req  in  1  pulse: toggle flag on cursor cell
- cell_mine  in  1  RAM read data, valid 1 cycle after addr
- cell_open  in  1  RAM read data
- cell_flag  in  1  RAM read data
- addr_row  out  $clog2(ROWS)  RAM address row (sweep counter in CLEAR, else cursor)
- addr_col  out  $clog2(COLS)  RAM address column
- wr_en  out  1  RAM write strobe
- wr_open  out  1  write data: open bit
- wr_flag  out  1  write data: flag bit
- cur_row  out  $clog2(ROWS)  cursor row (display)
- cur_col  out  $clog2(COLS)  cursor column
- flags_left  out  $clog2(MINES+1)  remaining flag budget
- opened_cnt  out  $clog2(ROWS*COLS+1)  safe cells revealed
- busy  out  1  high in every state except PLAY
- game_over  out  1  sticky: mine revealed
- win  out  1  sticky: all safe cells revealed

Behaviour:
- Reset (clk edge with rst=1): state CLEAR, sweep=0, cursor=(0,0), flags_left=MINES, opened_cnt=0, game_over=0, win=0, wr_en=0. Mid-operation reset restarts the sweep at cell 0.
- States: CLEAR, PLAY, FLAG_RD, FLAG_WR, SEL_RD, SEL_WR, LOSE, WIN.
- CLEAR: addr=sweep counter, row-major; wr_en=1, wr_open=0, wr_flag=0 each cycle; the mine bit is not written. After the last cell (ROWS-1,COLS-1) go to PLAY. Duration is exactly ROWS*COLS cycles. Cursor and counters are reset on entry.
- start has the highest priority in every state: the next state is CLEAR with counters, cursor, game_over and win cleared.
- PLAY arbitration for simultaneous requests: sel_req > flag_req > move_req. Lower-priority requests in that cycle are dropped. All requests outside PLAY are dropped.
- Move: cursor updates on the next edge; stays in PLAY. At edges the cursor saturates (see Optional Feature).
- Flag: PLAY -> FLAG_RD (address presented) -> FLAG_WR (data valid), evaluated in FLAG_WR:
  - open cell: no write
  - flagged cell: write flag=0, flags_left+1
  - unflagged, flags_left>0: write flag=1, flags_left-1
  - flags_left=0: no write
  - Then return to PLAY. Total 2 cycles.
- Select: PLAY -> SEL_RD -> SEL_WR, evaluated in SEL_WR:
  - open or flagged cell: no write, PLAY
  - mine: write open=1, game_over=1, LOSE
  - otherwise: write open=1, opened_cnt+1; if the new count equals ROWS*COLS-MINES go to WIN (win=1), else PLAY.
- wr_open/wr_flag during a flag write: wr_open=cell_open, wr_flag=new value. During a reveal write: wr_open=1, wr_flag=0.
- LOSE/WIN: terminal. Outputs hold; only start or rst leaves.
- Counters never overflow: flags_left is bounded [0,MINES]; opened_cnt is bounded by ROWS*COLS-MINES.

Optional Feature:
- Macro: MINES_CURSOR_WRAP_EN.
- Defined: cursor wraps at edges (up from row 0 -> ROWS-1, right from COLS-1 -> 0, etc.).
- Undefined: cursor saturates at edges (a move past an edge leaves the cursor unchanged).

Decomposition:
- Package mines_pkg holds:
  - state_t enum (8 states)
  - dir constants DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT
  - width helper functions
- Sub-module mines_cursor: cursor registers, dir decode, wrap/saturate logic. Ports: clk, rst, clr, step, dir, cur_row, cur_col.

Test Plan:
- Reset with ROWS=COLS=4 -> 16 wr_en cycles with addr 0..15 row-major, then busy=0, flags_left=MINES, cursor (0,0).
- Cursor at (0,0): move dir=0 and dir=2 -> stays (0,0) without wrap; with MINES_CURSOR_WRAP_EN -> (3,0), then (3,3).
- Flag an unflagged safe cell twice -> flags_left MINES-1 then MINES. With flags_left=0, flag a new cell -> no wr_en.
- Reveal a mine cell -> wr_en with wr_open=1 in SEL_WR, game_over=1. Further sel/move/flag are ignored; start -> CLEAR.
- 4x4 board, MINES=1: reveal all 15 safe cells -> win=1 on the 15th reveal, opened_cnt=15. A re-reveal of an open cell -> no write, count unchanged.
- Assert sel_req and move_req in the same PLAY cycle -> reveal only, cursor unchanged. Assert start during FLAG_RD -> CLEAR next cycle, no flag write.
